per_master_arbiter: RTL and testbench

Round-robin arbiter that shares one peripheral master port (req/gnt request channel, in-order r_valid response channel) between NUM_IN requesters, e.g. axi2per, debug and DMA config masters, ahead of the cluster peripheral interconnect. It tracks the requester of every granted transaction in an ID FIFO so that in-order responses route back to the correct requester, and it throttles new grants when the FIFO is full.

---
 rtl/per_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_per_master_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/per_master_arbiter.sv
// per_master_arbiter: round-robin share of one peripheral master port.
// Define PER_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module per_master_arbiter #(
  parameter int NUM_IN          = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_IN-1:0]              slv_req_i,
  input  logic [NUM_IN*ADDR_WIDTH-1:0]   slv_add_i,
  input  logic [NUM_IN-1:0]              slv_wen_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   slv_wdata_i,
  input  logic [NUM_IN*DATA_WIDTH/8-1:0] slv_be_i,
  output logic [NUM_IN-1:0]              slv_gnt_o,
  output logic [NUM_IN-1:0]              slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]          slv_r_rdata_o,
  output logic                           slv_r_opc_o,
  output logic                           per_req_o,
  output logic [ADDR_WIDTH-1:0]          per_add_o,
  output logic                           per_wen_o,
  output logic [DATA_WIDTH-1:0]          per_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        per_be_o,
  input  logic                           per_gnt_i,
  input  logic                           per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          per_r_rdata_i,
  input  logic                           per_r_opc_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_IN);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] add_a   [NUM_IN];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_IN];
  logic [BW-1:0]         be_a    [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign add_a[g]   = slv_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = slv_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_a[g]    = slv_be_i[g*BW +: BW];
  end

  logic [IW-1:0] mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          hs;
  logic          pop;
  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  int            idx;

`ifndef PER_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_ptr;
`endif

  assign fifo_full  = (cnt == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt == '0);

  // pick first requester at/after the priority pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
`ifdef PER_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
`endif
      cand = IW'(idx);
      if (!found && slv_req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign per_req_o = found & ~fifo_full;
  assign hs        = per_req_o & per_gnt_i;
  assign pop       = per_r_valid_i & ~fifo_empty;

  // steer winner payload to the master port
  always_comb begin
    per_add_o   = '0;
    per_wen_o   = 1'b0;
    per_wdata_o = '0;
    per_be_o    = '0;
    if (found) begin
      per_add_o   = add_a[win];
      per_wen_o   = slv_wen_i[win];
      per_wdata_o = wdata_a[win];
      per_be_o    = be_a[win];
    end
  end

  // grant back to winner, response to FIFO head
  always_comb begin
    slv_gnt_o     = '0;
    slv_r_valid_o = '0;
    if (hs)  slv_gnt_o[win] = 1'b1;
    if (pop) slv_r_valid_o[mem[rd_ptr]] = 1'b1;
  end

  assign slv_r_rdata_o = per_r_rdata_i;
  assign slv_r_opc_o   = per_r_opc_i;
  assign busy_o        = ~fifo_empty | (|slv_req_i);

  // ID storage, no reset needed: guarded by cnt
  always_ff @(posedge clk_i) begin
    if (hs) mem[wr_ptr] <= win;
  end

  // pointers, occupancy, sticky error, rr pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_o  <= 1'b0;
`ifndef PER_ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      if (hs) begin
        wr_ptr <= wr_ptr + 1'b1;
`ifndef PER_ARB_FIXED_PRIO_EN
        rr_ptr <= (win == IW'(NUM_IN - 1)) ? '0 : win + 1'b1;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (hs && !pop) cnt <= cnt + 1'b1;
      else if (pop && !hs) cnt <= cnt - 1'b1;
      if (per_r_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_per_master_arbiter.sv
// tb_per_master_arbiter: directed steps against a queue-based
// scoreboard of granted requester IDs.
module tb_per_master_arbiter;

  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    slv_req;
  logic [N*AW-1:0] slv_add;
  logic [N-1:0]    slv_wen;
  logic [N*DW-1:0] slv_wdata;
  logic [N*4-1:0]  slv_be;
  logic [N-1:0]    slv_gnt;
  logic [N-1:0]    slv_rv;
  logic [DW-1:0]   slv_rdata;
  logic            slv_opc;
  logic            per_req;
  logic [AW-1:0]   per_add;
  logic            per_wen;
  logic [DW-1:0]   per_wdata;
  logic [3:0]      per_be;
  logic            per_gnt;
  logic            per_rv;
  logic [DW-1:0]   per_rdata;
  logic            per_opc;
  logic            busy;
  logic            err;

  int n_chk  = 0;
  int n_fail = 0;
  int m_q[$];
  int m_rr;
  bit m_err;

  per_master_arbiter #(
    .NUM_IN(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_add_i(slv_add),
    .slv_wen_i(slv_wen), .slv_wdata_i(slv_wdata),
    .slv_be_i(slv_be), .slv_gnt_o(slv_gnt),
    .slv_r_valid_o(slv_rv), .slv_r_rdata_o(slv_rdata),
    .slv_r_opc_o(slv_opc), .per_req_o(per_req),
    .per_add_o(per_add), .per_wen_o(per_wen),
    .per_wdata_o(per_wdata), .per_be_o(per_be),
    .per_gnt_i(per_gnt), .per_r_valid_i(per_rv),
    .per_r_rdata_i(per_rdata), .per_r_opc_i(per_opc),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] add_of(int i);
    return 32'hA000_0000 + 32'(i * 16);
  endfunction

  function automatic logic [DW-1:0] wd_of(int i);
    return 32'h1111_0000 + 32'(i);
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    slv_req = '0;
    per_gnt = 1'b0;
    per_rv  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // one clock: drive, check against model, advance model
  task automatic step(input logic [N-1:0] r,
                      input logic g, input logic rv);
    int   w;
    bit   f;
    bit   pr;
    bit   pop;
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    logic [DW-1:0] rd;
    rd        = $urandom;
    slv_req   = r;
    per_gnt   = g;
    per_rv    = rv;
    per_rdata = rd;
    per_opc   = 1'($urandom_range(0, 1));
    #1;
    f = 1'b0;
    w = 0;
    for (int i = 0; i < N; i++) begin
      int c;
`ifdef PER_ARB_FIXED_PRIO_EN
      c = i;
`else
      c = (m_rr + i) % N;
`endif
      if (!f && r[c]) begin
        f = 1'b1;
        w = c;
      end
    end
    pr  = f && (m_q.size() < MAXO);
    eg  = (pr && g) ? N'(1 << w) : '0;
    pop = rv && (m_q.size() > 0);
    erv = pop ? N'(1 << m_q[0]) : '0;
    chk("per_req", 64'(per_req), 64'(pr));
    chk("slv_gnt", 64'(slv_gnt), 64'(eg));
    chk("slv_r_valid", 64'(slv_rv), 64'(erv));
    chk("per_add", 64'(per_add),
        f ? 64'(add_of(w)) : 64'd0);
    chk("per_wdata", 64'(per_wdata),
        f ? 64'(wd_of(w)) : 64'd0);
    chk("r_rdata", 64'(slv_rdata), 64'(rd));
    chk("busy", 64'(busy),
        64'((m_q.size() > 0) || (|r)));
    chk("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    else if (rv) m_err = 1'b1;
    if (pr && g) begin
      m_q.push_back(w);
      m_rr = (w + 1) % N;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      slv_add[i*AW +: AW]   = add_of(i);
      slv_wdata[i*DW +: DW] = wd_of(i);
    end
    slv_wen   = 3'b101;
    slv_be    = '1;
    per_rdata = '0;
    per_opc   = 1'b0;

    // reset state
    do_reset();
    step(3'b000, 1'b0, 1'b0);

    // all requesting, 1-cycle responses: 0,1,2,0,1,2
    step(3'b111, 1'b1, 1'b0);
    repeat (5) step(3'b111, 1'b1, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);

    // requester 2 alone, grant delayed 3 cycles
    do_reset();
    repeat (3) step(3'b100, 1'b0, 1'b0);
    step(3'b100, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1);
    step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1);

    // fill FIFO, pop while full, resume next cycle
    do_reset();
    repeat (6) step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b1);
    step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    repeat (5) step(3'b000, 1'b0, 1'b1);

    // push+pop at count 2, order kept over 10 responses
    do_reset();
    repeat (2) step(3'b111, 1'b1, 1'b0);
    repeat (10) step(3'b111, 1'b1, 1'b1);
    repeat (2) step(3'b011, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);

    // two steady requesters
    do_reset();
    repeat (6) step(3'b011, 1'b1, 1'b1);
    step(3'b000, 1'b0, 1'b1);

    // response with empty FIFO, sticky error
    do_reset();
    step(3'b000, 1'b0, 1'b1);
    repeat (3) step(3'b000, 1'b0, 1'b0);
    step(3'b001, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1);
    do_reset();
    step(3'b000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
